// File: rtl/cpu_loader.sv
// rtl/cpu_loader.sv - host-side program loader, run sequencer and DRAM dump engine for the A-RISC cpu
//
// Purpose:
//   Accepts a byte frame from the host (N, BASE, LEN, then N 16-bit instructions, low byte first).
//   It writes the instructions into IRAM, pulses cpu_start and waits for the cpu to go idle or
//   for TIMEOUT cycles to pass. It then streams DRAM[BASE .. BASE+LEN-1] (mod 256) back to the host.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready/s_data   host input byte stream
//   m_valid/m_ready/m_data   output byte stream of DRAM contents, m_last on final byte
//   iram_we/waddr/wdata      IRAM write port (one instruction per write)
//   cpu_start, cpu_idle      cpu start pulse and idle flag
//   dram_sel, dram_addr      DRAM ownership (1 = loader) and loader read address
//   dram_dout                DRAM read data, one cycle after dram_addr
//   busy, done, err          status: not idle, job-complete pulse, sticky timeout
//   run_cycles               RUN-state cycle count of the last job, saturating
module cpu_loader #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        iram_we,
  output logic [7:0]  iram_waddr,
  output logic [15:0] iram_wdata,
  output logic        cpu_start,
  input  logic        cpu_idle,
  output logic        dram_sel,
  output logic [7:0]  dram_addr,
  input  logic [7:0]  dram_dout,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] run_cycles
);

  typedef enum logic [3:0] {
    H_NUM, H_BASE, H_LEN, I_LO, I_HI, START, RUN, D_RD, D_WAIT, D_OUT, DONE
  } state_t;

  state_t      state, state_n;
  logic [7:0]  num, base, len, lo, icnt, dcnt;
  logic [15:0] run_cnt;
  logic        s_acc, m_acc;
  logic [15:0] run_inc;
  logic [16:0] run_nxt;
  logic        timeout_hit, idle_ok;

  assign s_acc = s_valid & s_ready;
  assign m_acc = m_valid & m_ready;

  // Saturating RUN counter; the timeout compare uses the post-increment value,
  // so the job leaves RUN after exactly TIMEOUT cycles there.
  assign run_inc     = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;
  assign run_nxt     = {1'b0, run_cnt} + 17'd1;
  assign timeout_hit = (run_nxt >= 17'(TIMEOUT));
  // cpu_idle may still reflect the previous job on the first RUN cycle.
  assign idle_ok     = cpu_idle && (run_cnt != 16'd0);

  assign busy       = (state != H_NUM);
  assign run_cycles = run_cnt;
  assign iram_waddr = icnt;
  assign iram_wdata = iram_we ? {s_data, lo} : 16'd0;
  assign dram_addr  = base + dcnt;

  always_comb begin
    state_n   = state;
    s_ready   = 1'b0;
    iram_we   = 1'b0;
    cpu_start = 1'b0;
    dram_sel  = 1'b1;
    done      = 1'b0;
    case (state)
      H_NUM: begin
        s_ready = !rst;
        if (s_acc) state_n = H_BASE;
      end
      H_BASE: begin
        s_ready = !rst;
        if (s_acc) state_n = H_LEN;
      end
      H_LEN: begin
        s_ready = !rst;
        if (s_acc) state_n = (num == 8'd0) ? START : I_LO;
      end
      I_LO: begin
        s_ready = !rst;
        if (s_acc) state_n = I_HI;
      end
      I_HI: begin
        s_ready = !rst;
        iram_we = s_acc;
        if (s_acc) state_n = (icnt == num - 8'd1) ? START : I_LO;
      end
      START: begin
        cpu_start = 1'b1;
        dram_sel  = 1'b0;
        state_n   = RUN;
      end
      RUN: begin
        dram_sel = 1'b0;
        if (idle_ok || timeout_hit) state_n = (len == 8'd0) ? DONE : D_RD;
      end
      D_RD:   state_n = D_WAIT;
      D_WAIT: state_n = D_OUT;
      D_OUT: begin
        if (m_acc) state_n = m_last ? DONE : D_RD;
      end
      DONE: begin
        done    = 1'b1;
        state_n = H_NUM;
      end
      default: state_n = H_NUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= H_NUM;
      num     <= 8'd0;
      base    <= 8'd0;
      len     <= 8'd0;
      lo      <= 8'd0;
      icnt    <= 8'd0;
      dcnt    <= 8'd0;
      run_cnt <= 16'd0;
      err     <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= 8'd0;
      m_last  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        H_NUM: if (s_acc) begin
          num <= s_data;
          err <= 1'b0;
        end
        H_BASE: if (s_acc) base <= s_data;
        H_LEN: if (s_acc) begin
          len  <= s_data;
          icnt <= 8'd0;
          dcnt <= 8'd0;
        end
        I_LO: if (s_acc) lo <= s_data;
        I_HI: if (s_acc) icnt <= icnt + 8'd1;
        START: run_cnt <= 16'd0;
        RUN: begin
          run_cnt <= run_inc;
          if (!idle_ok && timeout_hit) err <= 1'b1;
        end
        D_WAIT: begin
          m_data  <= dram_dout;
          m_valid <= 1'b1;
          m_last  <= (dcnt == len - 8'd1);
        end
        D_OUT: if (m_acc) begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          dcnt    <= dcnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_loader.sv
// tb/tb_cpu_loader.sv - directed scoreboard bench for cpu_loader
module tb_cpu_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'd0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_last;
  logic        iram_we;
  logic [7:0]  iram_waddr;
  logic [15:0] iram_wdata;
  logic        cpu_start;
  logic        cpu_idle = 1'b1;
  logic        dram_sel;
  logic [7:0]  dram_addr;
  logic [7:0]  dram_dout = 8'd0;
  logic        busy, done, err;
  logic [15:0] run_cycles;

  cpu_loader #(.TIMEOUT(20)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .iram_we(iram_we), .iram_waddr(iram_waddr), .iram_wdata(iram_wdata),
    .cpu_start(cpu_start), .cpu_idle(cpu_idle),
    .dram_sel(dram_sel), .dram_addr(dram_addr), .dram_dout(dram_dout),
    .busy(busy), .done(done), .err(err), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [256];
  logic [15:0] prog [4];
  logic [23:0] iram_q [$];
  logic [8:0]  m_q [$];
  int done_cnt = 0, start_cnt = 0, mbyte_cnt = 0;

  // cpu model: busy_len cycles from start until idle (0 = stays idle, hang = never idle)
  int   busy_len = 5;
  bit   hang = 0;
  int   ccnt = 0;
  always @(posedge clk) begin
    dram_dout <= mem[dram_addr];
    if (cpu_start) begin
      if (hang) begin cpu_idle <= 1'b0; ccnt <= 0; end
      else if (busy_len == 0) begin cpu_idle <= 1'b1; ccnt <= 0; end
      else begin cpu_idle <= 1'b0; ccnt <= 1; end
    end else if (ccnt != 0) begin
      if (ccnt >= busy_len - 1) begin cpu_idle <= 1'b1; ccnt <= 0; end
      else ccnt <= ccnt + 1;
    end
  end

  // Monitor: pops scoreboard entries and checks hold-while-stalled behaviour
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (cpu_start) start_cnt++;
    if (prev_stall) begin
      checks++;
      assert (m_valid === 1'b1 && m_data === prev_data && m_last === prev_last)
      else begin
        errors++;
        $error("FAIL stall_hold: observed v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
               m_valid, m_data, m_last, prev_data, prev_last);
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (m_valid && m_ready) begin
      logic [8:0] e;
      mbyte_cnt++;
      e = (m_q.size() != 0) ? m_q.pop_front() : 9'h1FF;
      checks++;
      assert ({m_last, m_data} === e)
      else begin
        errors++;
        $error("FAIL m_byte: observed last=%0b data=%0h expected last=%0b data=%0h",
               m_last, m_data, e[8], e[7:0]);
      end
    end
    if (iram_we) begin
      logic [23:0] w;
      w = (iram_q.size() != 0) ? iram_q.pop_front() : 24'hFFFFFF;
      checks++;
      assert ({iram_waddr, iram_wdata} === w)
      else begin
        errors++;
        $error("FAIL iram_write: observed addr=%0h data=%0h expected addr=%0h data=%0h",
               iram_waddr, iram_wdata, w[23:16], w[15:0]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    chk("send_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] n, input logic [7:0] b, input logic [7:0] l);
    for (int i = 0; i < int'(l); i++)
      m_q.push_back({(i == int'(l) - 1), mem[8'(int'(b) + i)]});
    send_byte(n);
    send_byte(b);
    send_byte(l);
    for (int i = 0; i < int'(n); i++) begin
      send_byte(prog[i][7:0]);
      iram_q.push_back({8'(i), prog[i]});
      send_byte(prog[i][15:8]);
    end
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("done_pulse", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC;
    prog[0] = 16'h1234; prog[1] = 16'h0000; prog[2] = 16'hBEEF; prog[3] = 16'h0F0F;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dram_sel", 32'(dram_sel), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_run_cycles", 32'(run_cycles), 32'd0);
    chk("rst_cpu_start", 32'(cpu_start), 32'd0);
    @(posedge clk); #1;

    // Job A: two instructions, no dump
    busy_len = 5; hang = 0;
    send_frame(8'd2, 8'h10, 8'd0);
    wait_done(1);
    chk("A_starts", 32'(start_cnt), 32'd1);
    chk("A_no_mbytes", 32'(mbyte_cnt), 32'd0);
    chk("A_iram_q_empty", 32'(iram_q.size()), 32'd0);
    chk("A_run_cycles", 32'(run_cycles), 32'd5);
    chk("A_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // Job B: same program, dump AA,BB,CC
    send_frame(8'd2, 8'h10, 8'd3);
    wait_done(2);
    chk("B_m_q_empty", 32'(m_q.size()), 32'd0);
    chk("B_mbytes", 32'(mbyte_cnt), 32'd3);
    chk("B_run_cycles", 32'(run_cycles), 32'd5);
    chk("B_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Job C: back-pressure for 10 cycles after the first dumped byte
    send_frame(8'd1, 8'h10, 8'd3);
    begin
      int k = 0;
      while (!(mbyte_cnt == 4 && m_valid) && k < 500) begin @(negedge clk); k++; end
      chk("C_reach_stall", 32'(mbyte_cnt), 32'd4);
    end
    @(posedge clk); #1 m_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1 m_ready = 1'b1;
    wait_done(3);
    chk("C_m_q_empty", 32'(m_q.size()), 32'd0);
    chk("C_mbytes", 32'(mbyte_cnt), 32'd6);
    @(posedge clk); #1;

    // Job D: no instructions, address wrap, cpu already idle (first-cycle idle ignored)
    busy_len = 0;
    send_frame(8'd0, 8'hFE, 8'd4);
    wait_done(4);
    chk("D_m_q_empty", 32'(m_q.size()), 32'd0);
    chk("D_run_cycles", 32'(run_cycles), 32'd2);
    chk("D_starts", 32'(start_cnt), 32'd4);
    @(posedge clk); #1;

    // Job E: cpu never idles, timeout after 20 RUN cycles, dump still runs
    hang = 1;
    send_frame(8'd1, 8'h20, 8'd2);
    wait_done(5);
    chk("E_err", 32'(err), 32'd1);
    chk("E_run_cycles", 32'(run_cycles), 32'd20);
    chk("E_m_q_empty", 32'(m_q.size()), 32'd0);
    @(posedge clk); #1;

    // Job F: err clears on N accept, then reset while in I_HI
    hang = 0; busy_len = 5;
    send_byte(8'd2);
    chk("F_err_cleared", 32'(err), 32'd0);
    chk("F_busy", 32'(busy), 32'd1);
    send_byte(8'h00);
    send_byte(8'd1);
    send_byte(8'h77);
    s_valid = 1'b1; s_data = 8'h66; rst = 1'b1;
    @(negedge clk);
    chk("F_rst_iram_we", 32'(iram_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("F_post_rst_busy", 32'(busy), 32'd0);
    chk("F_post_rst_s_ready", 32'(s_ready), 32'd1);
    chk("F_post_rst_m_valid", 32'(m_valid), 32'd0);
    chk("F_iram_q_empty", 32'(iram_q.size()), 32'd0);
    @(posedge clk); #1;

    // Job G: recovery after reset
    prog[0] = 16'hC3A5;
    send_frame(8'd1, 8'h00, 8'd1);
    wait_done(6);
    chk("G_m_q_empty", 32'(m_q.size()), 32'd0);
    chk("G_iram_q_empty", 32'(iram_q.size()), 32'd0);
    chk("G_run_cycles", 32'(run_cycles), 32'd5);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
